// File: rtl/rr_arb4_enc.sv
// rr_arb4_enc: 4-way round-robin arbiter driving a 2-to-4 one-hot decoder (e = enable, a = select).
// Every grant is followed by at least one idle cycle, so the decoded lines never hop owner-to-owner.
module rr_arb4_enc #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       rel,
   output logic       e,
   output logic [1:0] a
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];

   state_t     state_r;
   logic [1:0] ptr_r;
   logic [7:0] hold_cnt_r;

   logic       pick_vld_s;
   logic [1:0] pick_idx_s;
   logic       hold_hit_s;
   logic       end_s;

   // First requester at or after p, searching p, p+1, p+2, p+3 with 2-bit wrap.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         res = r[idx] ? {1'b1, idx} : res;
      end
      return res;
   endfunction

   // Arbitration choice and grant-termination conditions.
   always_comb begin
      {pick_vld_s, pick_idx_s} = rr_pick(req, ptr_r);
      hold_hit_s = (HOLD_LIM != 8'd0) && (hold_cnt_r == HOLD_LIM);
      end_s      = ~req[a] | rel | hold_hit_s;
   end

   // Arbiter state machine with registered decoder drives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         e          <= 1'b0;
         a          <= 2'b00;
         ptr_r      <= 2'b00;
         hold_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_vld_s) begin
                  a          <= pick_idx_s;
                  e          <= 1'b1;
                  hold_cnt_r <= 8'd1;
                  state_r    <= GRANT;
               end else begin
                  e <= 1'b0;
               end
            end
            GRANT: begin
               if (end_s) begin
                  e          <= 1'b0;
                  state_r    <= IDLE;
                  ptr_r      <= a + 2'd1;
                  hold_cnt_r <= 8'd0;
               end else if (hold_cnt_r != 8'd255) begin
                  hold_cnt_r <= hold_cnt_r + 8'd1;
               end else begin
                  hold_cnt_r <= hold_cnt_r;
               end
            end
            default: begin
               state_r    <= IDLE;
               e          <= 1'b0;
               hold_cnt_r <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Randomized and directed bench for rr_arb4_enc; two instances (MAX_HOLD 8 and 4) checked
// every cycle against an owner/priority reference model.
module tb_rr_arb4_enc;

   logic       clk;
   logic       rst_s;
   logic [3:0] req_s;
   logic       rel_s;
   logic       e8_s, e4_s;
   logic [1:0] a8_s, a4_s;

   int tests_run;
   int tests_failed;

   // Reference model state: owner is -1 when nobody holds the resource.
   int owner  [2];
   int last_a [2];
   int nxt    [2];
   int run    [2];
   int lim    [2];

   rr_arb4_enc #(.MAX_HOLD(8)) dut8 (
      .clk(clk), .rst(rst_s), .req(req_s), .rel(rel_s), .e(e8_s), .a(a8_s)
   );

   rr_arb4_enc #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst_s), .req(req_s), .rel(rel_s), .e(e4_s), .a(a4_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [2:0] got, input logic [2:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got {e,a}=%b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input int m);
      bit ended;
      int c;
      if (rst_s) begin
         owner[m] = -1; last_a[m] = 0; nxt[m] = 0; run[m] = 0;
      end else if (owner[m] < 0) begin
         for (int k = 0; k < 4; k++) begin
            c = (nxt[m] + k) % 4;
            if (owner[m] < 0 && req_s[c]) begin
               owner[m] = c; last_a[m] = c; run[m] = 1;
            end
         end
      end else begin
         ended = !req_s[owner[m]] || rel_s || (lim[m] != 0 && run[m] >= lim[m]);
         if (ended) begin
            nxt[m] = (owner[m] + 1) % 4; owner[m] = -1; run[m] = 0;
         end else if (run[m] < 255) begin
            run[m]++;
         end
      end
   endtask

   function automatic logic [2:0] expected(input int m);
      logic [1:0] aa;
      aa = 2'(last_a[m]);
      return {owner[m] >= 0, aa};
   endfunction

   task automatic do_cycle(input string tag, input logic [3:0] r, input logic rl, input logic rs);
      req_s = r; rel_s = rl; rst_s = rs;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_value({tag, "/h8"}, {e8_s, a8_s}, expected(0));
      check_value({tag, "/h4"}, {e4_s, a4_s}, expected(1));
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      lim[0] = 8; lim[1] = 4;
      for (int m = 0; m < 2; m++) begin
         owner[m] = -1; last_a[m] = 0; nxt[m] = 0; run[m] = 0;
      end
      req_s = 4'b0000; rel_s = 1'b0; rst_s = 1'b1;
      @(negedge clk);

      // Reset held with every requester active, then first grant to 0.
      do_cycle("reset",  4'b1111, 1'b0, 1'b1);
      do_cycle("reset",  4'b1111, 1'b0, 1'b1);
      do_cycle("rstrel", 4'b1111, 1'b0, 1'b0);

      // Single requester with release on the third grant cycle.
      do_cycle("single", 4'b0100, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) do_cycle("single", 4'b0100, 1'b0, 1'b0);
      do_cycle("single", 4'b0100, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) do_cycle("single", 4'b0100, 1'b0, 1'b0);

      // Round-robin with release every cycle.
      do_cycle("rr", 4'b1111, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) do_cycle("rr", 4'b1111, 1'b1, 1'b0);

      // Hold limit with two requesters and no release.
      do_cycle("hold", 4'b1010, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) do_cycle("hold", 4'b1010, 1'b0, 1'b0);

      // Request drop and wrap-around search to requester 3.
      do_cycle("drop", 4'b0001, 1'b0, 1'b1);
      do_cycle("drop", 4'b0001, 1'b0, 1'b0);
      do_cycle("drop", 4'b1001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) do_cycle("drop", 4'b1000, 1'b0, 1'b0);

      // Reset in the middle of a grant to requester 2.
      do_cycle("rstmid", 4'b0100, 1'b0, 1'b1);
      do_cycle("rstmid", 4'b0100, 1'b0, 1'b0);
      do_cycle("rstmid", 4'b0100, 1'b0, 1'b0);
      do_cycle("rstmid", 4'b0100, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) do_cycle("rstmid", 4'b0100, 1'b0, 1'b0);

      // Release in idle is ignored.
      do_cycle("idlerel", 4'b0000, 1'b1, 1'b0);
      do_cycle("idlerel", 4'b0010, 1'b1, 1'b0);
      do_cycle("idlerel", 4'b0010, 1'b0, 1'b0);

      // Randomized traffic: sticky requests, sparse release and reset.
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] r;
         r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req_s;
         do_cycle("rand", r, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
